// File: rtl/univ_shift_register.sv
// univ_shift_register
//   N-bit universal register with a per-cycle op code and an autonomous burst
//   shifter. It serves as a datapath register and as a serialiser for
//   SPI/UART-style front ends.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   op           per-cycle operation (hold/load/shl/shr/rotl/rotr/asr/clear),
//                used only in IDLE
//   I            parallel load data
//   sin_l        serial in at the LSB, used by left shifts
//   sin_r        serial in at the MSB, used by right shifts
//   burst_start  start-burst request, sampled in IDLE
//   burst_len    number of burst shifts, captured together with burst_start
//   burst_dir    burst direction (0 = left, 1 = right), captured with burst_start
//   Q            register contents
//   sout_l       Q[N-1]
//   sout_r       Q[0]
//   busy         high while a burst is running
//   done         one-cycle pulse after the last burst shift
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | op codes act on Q; a burst_start request is accepted here
// BURST  | shift once per cycle in the captured direction until count hits 0
module univ_shift_register #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       op,
    input  logic [N-1:0]     I,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic [N-1:0]     Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROTL  = 3'b100;
    localparam logic [2:0] OP_ROTR  = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    state_t             state_q, state_d;
    logic [N-1:0]       q_r, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_r     <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_r     <= q_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_r;
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_start) begin
                    // Q holds on the start edge; a zero-length burst just reports done.
                    if (burst_len != '0) begin
                        count_d = burst_len;
                        dir_d   = burst_dir;
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    case (op)
                        OP_HOLD:  q_d = q_r;
                        OP_LOAD:  q_d = I;
                        OP_SHL:   q_d = {q_r[N-2:0], sin_l};
                        OP_SHR:   q_d = {sin_r, q_r[N-1:1]};
                        OP_ROTL:  q_d = {q_r[N-2:0], q_r[N-1]};
                        OP_ROTR:  q_d = {q_r[0], q_r[N-1:1]};
                        OP_ASR:   q_d = {q_r[N-1], q_r[N-1:1]};
                        OP_CLEAR: q_d = '0;
                        default:  q_d = q_r;
                    endcase
                end
            end
            BURST: begin
                q_d     = dir_q ? {sin_r, q_r[N-1:1]} : {q_r[N-2:0], sin_l};
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Q      = q_r;
    assign sout_l = q_r[N-1];
    assign sout_r = q_r[0];
    assign busy   = (state_q == BURST);
    assign done   = done_q;

endmodule
